sort_engine: RTL and testbench

Sequential in-place sorter that sits directly downstream of the unsigned comparator (`sltu`) in the datapath. It accepts a block of `DEPTH` unsigned words over a valid/ready stream and bubble-sorts them in ascending order. It uses exactly one structural `sltu` instance, doing one compare-and-swap per cycle, then streams the sorted block out over a second valid/ready stream. It is the first multi-cycle consumer of the comparator and exercises it under real control flow.

---
 rtl/sort_engine.sv | 157 +++++++++++++++
 tb/tb_sort_engine.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sort_engine.sv
// sort_engine: in-place bubble sorter for one block of DEPTH unsigned words.
//
// A block is loaded over the in_* valid/ready stream. It is then sorted in
// ascending unsigned order, one compare-and-swap per cycle, through a single
// sltu comparator. The sorted block is drained over the out_* stream.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   in_valid   upstream word valid
//   in_data    upstream word (unsigned, N bits)
//   in_ready   engine accepts a word (LOAD phase)
//   out_valid  sorted word valid (OUT phase)
//   out_data   sorted word
//   out_last   final word of the block
//   out_ready  downstream accepts the word
//   busy       sorting or draining
//
// Every output is decoded from registered state only. No input reaches an
// output combinationally.

// Unsigned strict less-than: out = (a < b).
module sltu #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out
);
    assign out = (a < b);
endmodule

module sort_engine #(
    parameter int N     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy
);
    localparam int            KW    = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [KW-1:0] KLAST = KW'(DEPTH - 1);
    localparam logic [KW-1:0] JLAST = KW'(DEPTH - 2);

    typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

    state_t        state, state_n;
    logic [N-1:0]  sbuf [DEPTH];
    logic [KW-1:0] k, j, p, j1;
    logic          swapped;
    logic          lt;
    logic          pass_end, sort_done;
    logic          in_fire, out_fire;

    assign j1 = j + KW'(1);

    // The single comparator: the upper neighbour strictly below the lower one
    // means this pair is out of order. Equal words never swap.
    sltu #(.N(N)) u_cmp (
        .a   (sbuf[j1]),
        .b   (sbuf[j]),
        .out (lt)
    );

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign pass_end = (j == JLAST);
    // This cycle's swap counts toward the pass. A pass with no swaps means
    // the block is already ordered. After DEPTH-1 passes the block is
    // ordered regardless.
    assign sort_done = pass_end && (!(swapped || lt) || (p == JLAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_data  = sbuf[k];
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (k == KLAST)) state_n = SORT;
            end
            SORT: begin
                busy = 1'b1;
                if (sort_done) state_n = OUT;
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (k == KLAST);
                if (out_ready && (k == KLAST)) state_n = LOAD;
            end
            default: state_n = LOAD;
        endcase
    end

    // Index and pass bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= '0;
            j       <= '0;
            p       <= '0;
            swapped <= 1'b0;
        end else begin
            case (state)
                LOAD: if (in_fire) begin
                    if (k == KLAST) begin
                        k       <= '0;
                        j       <= '0;
                        p       <= '0;
                        swapped <= 1'b0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                SORT: begin
                    if (!pass_end) begin
                        j       <= j + KW'(1);
                        swapped <= swapped | lt;
                    end else if (!sort_done) begin
                        j       <= '0;
                        p       <= p + KW'(1);
                        swapped <= 1'b0;
                    end
                end
                OUT: if (out_fire) begin
                    k <= (k == KLAST) ? '0 : k + KW'(1);
                end
                default: ;
            endcase
        end
    end

    // Buffer contents are don't-care after reset, so the buffer has no reset.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_fire) begin
            sbuf[k] <= in_data;
        end else if (state == SORT && lt) begin
            sbuf[j]  <= sbuf[j1];
            sbuf[j1] <= sbuf[j];
        end
    end
endmodule

// File: tb/tb_sort_engine.sv
module tb_sort_engine;
    localparam int N = 32;
    localparam int D = 4;

    typedef logic [N-1:0] blk_t [D];
    typedef struct {
        blk_t w;        // words loaded
        blk_t e;        // sorted words expected
        int   sort_cyc; // SORT cycles expected
        int   gap;      // load index preceded by a 2-cycle in_valid gap (-1 none)
        int   rmode;    // 0: out_ready high, 1: out_ready 1,0,0,...
    } vec_t;
    typedef struct { logic [N-1:0] data; logic last; } exp_t;

    logic         clk = 0, rst = 1;
    logic         in_valid = 0, in_ready;
    logic [N-1:0] in_data = '0, out_data;
    logic         out_valid, out_last, out_ready = 0, busy;

    int   total = 0, passed = 0, sort_cnt = 0;
    exp_t exp_q[$];
    vec_t tbl[6];

    sort_engine #(.N(N), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Output monitor: sampled mid-cycle, away from the rising edge.
    logic         prev_stall = 0, prev_lastfire = 0, prev_last;
    logic [N-1:0] prev_data;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall    = 0;
            prev_lastfire = 0;
        end else begin
            if (busy && !out_valid) sort_cnt++;
            if (prev_stall && out_valid) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_last", {31'b0, out_last}, {31'b0, prev_last});
            end
            if (prev_lastfire) begin
                chk("turn_in_ready", {31'b0, in_ready}, 32'd1);
                chk("turn_out_valid", {31'b0, out_valid}, 32'd0);
            end
            prev_stall    = out_valid && !out_ready;
            prev_data     = out_data;
            prev_last     = out_last;
            prev_lastfire = out_valid && out_ready && out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", out_data, 32'hDEAD_BEEF);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("out_data", out_data, x.data);
                    chk("out_last", {31'b0, out_last}, {31'b0, x.last});
                end
            end
        end
    end

    task automatic load_block(input blk_t w, input blk_t e, input int gap, input bit push);
        int cnt;
        if (push) for (int i = 0; i < D; i++) exp_q.push_back('{e[i], i == D - 1});
        for (int i = 0; i < D; i++) begin
            if (i == gap) begin
                in_valid = 0;
                repeat (2) @(posedge clk);
                #1;
            end
            in_valid = 1;
            in_data  = w[i];
            cnt = 0;
            while (!in_ready && cnt < 200) begin
                @(posedge clk);
                #1;
                cnt++;
            end
            if (cnt >= 200) chk("load_timeout", 32'd1, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 0;
    endtask

    task automatic drain(input int rmode);
        int cnt = 0;
        while (exp_q.size() > 0 && cnt < 300) begin
            out_ready = (rmode == 0) ? 1'b1 : ((cnt % 3) == 0);
            @(posedge clk);
            #1;
            cnt++;
        end
        out_ready = 0;
        if (cnt >= 300) begin
            chk("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        tbl[0] = '{'{3, 1, 2, 0}, '{0, 1, 2, 3}, 9, -1, 0};
        tbl[1] = '{'{0, 1, 2, 3}, '{0, 1, 2, 3}, 3, -1, 0};
        tbl[2] = '{'{5, 5, 5, 5}, '{5, 5, 5, 5}, 3, -1, 0};
        tbl[3] = '{'{32'hFFFF_FFFF, 1, 32'h8000_0000, 0},
                   '{0, 1, 32'h8000_0000, 32'hFFFF_FFFF}, 9, -1, 0};
        tbl[4] = '{'{3, 2, 1, 0}, '{0, 1, 2, 3}, 9, 2, 1};
        tbl[5] = '{'{1, 0, 2, 3}, '{0, 1, 2, 3}, 6, 1, 1};

        repeat (2) @(posedge clk);
        #1 rst = 0;
        #2;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_last", {31'b0, out_last}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;

        for (int t = 0; t < 6; t++) begin
            sort_cnt = 0;
            load_block(tbl[t].w, tbl[t].e, tbl[t].gap, 1'b1);
            drain(tbl[t].rmode);
            chk($sformatf("sort_cycles[%0d]", t), sort_cnt, tbl[t].sort_cyc);
            @(posedge clk);
            #1;
        end

        // Reset in the second SORT cycle, then a fresh block.
        begin
            blk_t a, e;
            a = '{3, 2, 1, 0};
            e = '{0, 1, 2, 3};
            load_block(a, e, -1, 1'b0);
            @(posedge clk);
            #1 rst = 1;
            @(posedge clk);
            #1 rst = 0;
            #2;
            chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("mid_rst_busy", {31'b0, busy}, 32'd0);
            chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            a = '{2, 0, 3, 1};
            sort_cnt = 0;
            load_block(a, e, -1, 1'b1);
            drain(0);
            chk("sort_cycles_after_rst", sort_cnt, 32'd9);
            @(posedge clk);
            #1;
        end

        // Back-to-back blocks with in_valid held across A's final handshake.
        begin
            blk_t a, ea, b, eb;
            a  = '{3, 2, 1, 0};
            ea = '{0, 1, 2, 3};
            b  = '{7, 7, 0, 9};
            eb = '{0, 7, 7, 9};
            load_block(a, ea, -1, 1'b1);
            fork
                drain(0);
                load_block(b, eb, -1, 1'b1);
            join
            drain(0);
            chk("b2b_queue_empty", exp_q.size(), 32'd0);
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
